// File: rtl/if_stage_pkg.sv
// ============================================================================
// if_stage_pkg
// ----------------------------------------------------------------------------
// Definitions shared by the instruction-fetch stage and the decode-side
// controller that drives it:
//   - npc_sel_e    : 2-bit next-PC select codes (SEQ / BRANCH / JUMP / JR)
//   - NOP_INSTR    : encoding injected into IF/ID when a fetch is squashed
//   - RESET_PC_DEF : default PC after reset (word 0 of instruction memory)
//   - branch_offset: sign-extended, word-scaled branch displacement
// ============================================================================
package if_stage_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // Branch displacement: imm16 sign-extended and shifted left by two.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_npc_calc.sv
// ============================================================================
// npc_calc
// ----------------------------------------------------------------------------
// Purely combinational next-PC target mux.
// Ports:
//   pc          in  32  current fetch PC
//   if_id_pc4   in  32  PC+4 of the instruction currently in ID
//   npc_sel     in  2   effective select (already forced to SEQ by caller
//                       when a redirect is not allowed)
//   imm16       in  16  branch offset field
//   instr_index in  26  jump target field
//   rs_data     in  32  register value for JR
//   npc         out 32  selected next PC
// ============================================================================
module npc_calc
    import if_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc4,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic [31:0] npc
);

    logic [31:0] seq_tgt_s;
    logic [31:0] br_tgt_s;
    logic [31:0] j_tgt_s;
    logic [31:0] jr_tgt_s;

    assign seq_tgt_s = pc + 32'd4;
    // Branch target is relative to the delay-slot address (PC+4 of the branch).
    assign br_tgt_s  = if_id_pc4 + branch_offset(imm16);
    // Jump stays within the 256 MB region of the delay-slot address.
    assign j_tgt_s   = {if_id_pc4[31:28], instr_index, 2'b00};
    // JR forces word alignment; misaligned low bits are dropped silently.
    assign jr_tgt_s  = rs_data & 32'hFFFF_FFFC;

    // Target selection.
    always_comb begin
        npc = seq_tgt_s;
        case (npc_sel)
            NPC_SEQ: npc = seq_tgt_s;
            NPC_BR:  npc = br_tgt_s;
            NPC_J:   npc = j_tgt_s;
            NPC_JR:  npc = jr_tgt_s;
            default: npc = seq_tgt_s;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// ============================================================================
// if_stage
// ----------------------------------------------------------------------------
// MIPS instruction-fetch stage. Owns the PC, addresses the asynchronous-read
// instruction memory and captures the returned word into the IF/ID register.
// Next PC comes from npc_calc; stall has priority over redirect, and a bubble
// in ID can never redirect.
//
// Configuration macro: IF_DELAY_SLOT_EN
//   undefined : the word fetched in a redirect cycle is squashed (NOP, valid 0)
//   defined   : architectural branch delay slot, that word is kept (valid 1)
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   IM_AW     instruction-memory word-address width
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      asynchronous active-high reset
//   stall        in  1      hold PC and IF/ID
//   npc_sel      in  2      SEQ / BRANCH / JUMP / JR
//   imm16        in  16     branch offset of the instruction in ID
//   instr_index  in  26     jump target field of the instruction in ID
//   rs_data      in  32     register value for JR
//   imem_addr    out IM_AW  word address = pc[IM_AW+1:2]
//   imem_dout    in  32     instruction from memory (same cycle)
//   pc           out 32     current fetch PC
//   if_id_instr  out 32     latched instruction
//   if_id_pc4    out 32     latched PC+4 of that instruction
//   if_id_valid  out 1      latched instruction is real (0 = bubble)
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       npc_sel,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    input  logic [31:0]      rs_data,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_dout,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid
);

    logic [31:0] pc_r;
    logic [31:0] if_id_instr_r;
    logic [31:0] if_id_pc4_r;
    logic        if_id_valid_r;

    logic        redirect_s;
    logic [1:0]  eff_sel_s;
    logic [31:0] npc_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] instr_nxt_s;
    logic        valid_nxt_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // Memory sees only the word offset; higher PC bits alias silently.
    assign imem_addr   = pc_r[IM_AW+1:2];
    assign pc          = pc_r;
    assign if_id_instr = if_id_instr_r;
    assign if_id_pc4   = if_id_pc4_r;
    assign if_id_valid = if_id_valid_r;

    // Redirect qualification: a bubble in ID cannot steer the PC.
    always_comb begin
        redirect_s = 1'b0;
        eff_sel_s  = NPC_SEQ;
        if ((npc_sel != NPC_SEQ) && if_id_valid_r) begin
            redirect_s = 1'b1;
            eff_sel_s  = npc_sel;
        end else begin
            redirect_s = 1'b0;
            eff_sel_s  = NPC_SEQ;
        end
    end

    npc_calc u_npc_calc (
        .pc          (pc_r),
        .if_id_pc4   (if_id_pc4_r),
        .npc_sel     (eff_sel_s),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .npc         (npc_s)
    );

    // IF/ID next value: keep or squash the word fetched this cycle.
    always_comb begin
        instr_nxt_s = imem_dout;
        valid_nxt_s = 1'b1;
`ifdef IF_DELAY_SLOT_EN
        // Delay slot: the fetched word always executes, even on redirect.
        if (redirect_s) begin
            instr_nxt_s = imem_dout;
            valid_nxt_s = 1'b1;
        end else begin
            instr_nxt_s = imem_dout;
            valid_nxt_s = 1'b1;
        end
`else
        // The word fetched alongside a redirect is wrong-path.
        if (redirect_s) begin
            instr_nxt_s = NOP_INSTR;
            valid_nxt_s = 1'b0;
        end else begin
            instr_nxt_s = imem_dout;
            valid_nxt_s = 1'b1;
        end
`endif
    end

    // PC and IF/ID registers; stall freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            if_id_instr_r <= NOP_INSTR;
            if_id_pc4_r   <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
        end else if (!stall) begin
            pc_r          <= npc_s;
            if_id_instr_r <= instr_nxt_s;
            if_id_pc4_r   <= pc_plus4_s;
            if_id_valid_r <= valid_nxt_s;
        end else begin
            pc_r          <= pc_r;
            if_id_instr_r <= if_id_instr_r;
            if_id_pc4_r   <= if_id_pc4_r;
            if_id_valid_r <= if_id_valid_r;
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Computes the next PC from sequential, branch, jump and jump-register requests issued by decode; handles stall and control-hazard squash.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; bits [11:2] = 0, so fetch starts at memory word 0.
- IM_AW, 10, instruction-memory word-address width; 4 KB space, word addressed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  from hazard unit: hold PC and IF/ID.
- npc_sel  in  2  next-PC select: 00 SEQ, 01 BRANCH (taken), 10 JUMP, 11 JR.
- imm16  in  16  branch offset field of the instruction in ID.
- instr_index  in  26  jump target field of the instruction in ID.
- rs_data  in  32  register value for JR.
- imem_addr  out  IM_AW  word address to instruction memory = pc[IM_AW+1:2].
- imem_dout  in  32  instruction returned combinationally by instruction memory.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  latched instruction.
- if_id_pc4  out  32  latched PC+4 of that instruction.
- if_id_valid  out  1  latched instruction is real (0 = bubble).

Behaviour:
- Reset (async, rst=1):
  - pc = RESET_PC.
  - if_id_instr = 32'h0000_0000 (NOP).
  - if_id_pc4 = 0.
  - if_id_valid = 0.
  - Outputs hold these values while rst is high.
  - The first rising edge after rst falls latches imem_dout for RESET_PC.
- Fetch: imem_addr is combinational from pc. Memory is asynchronous read, so the instruction is available in the same cycle; IF latency is 1 cycle (PC to IF/ID).
- Next-PC, computed from ID-side inputs and if_id_pc4 (the PC+4 of the instruction in ID):
  - SEQ: pc + 4.
  - BRANCH: if_id_pc4 + (sign-extended imm16 << 2); 32-bit wrap.
  - JUMP: {if_id_pc4[31:28], instr_index, 2'b00}.
  - JR: {rs_data[31:2], 2'b00}; low two bits are silently dropped.
- Per rising edge, priority stall > redirect > sequential:
  - stall=1: pc, if_id_* all hold. npc_sel is ignored; decode re-presents it after the stall clears.
  - stall=0, npc_sel=SEQ:
    - pc <= pc + 4.
    - if_id_instr <= imem_dout, if_id_pc4 <= pc + 4, if_id_valid <= 1.
  - stall=0, npc_sel≠SEQ, if_id_valid=1:
    - pc <= target.
    - The instruction fetched this cycle is wrong-path: if_id_instr <= NOP, if_id_valid <= 0, if_id_pc4 <= pc + 4.
  - npc_sel≠SEQ while if_id_valid=0: treated as SEQ. A bubble cannot redirect.
- Address wrap: only pc[11:2] reaches memory. A PC beyond 4 KB aliases modulo 4 KB with no error. pc itself wraps at 2^32.
- pc[1:0] is always 00.

Optional Feature:
- Macro: IF_DELAY_SLOT_EN.
- Defined:
  - MIPS architectural branch delay slot.
  - On redirect, the instruction fetched in the same cycle is kept: valid=1, instr=imem_dout, pc4=pc+4.
  - PC still loads the target.
- Undefined: squash behaviour as above.

Decomposition:
- Shared package / include file holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR 2-bit codes, used by both controller and this block.
  - NOP_INSTR = 32'h0.
  - RESET_PC default.
- One sub-module: npc_calc. Purely combinational target mux with inputs pc, if_id_pc4, npc_sel, imm16, instr_index, rs_data, producing npc. The sequential logic stays in if_stage.

Test Plan:
- Reset release, memory words 0..3 = 37180000, 35080001, 35290004, 358c0024, SEQ, no stall:
  - pc steps 3000→3004→3008→300C; imem_addr 0,1,2,3.
  - if_id_instr follows one cycle behind; valid=1 from first edge.
- Stall high 2 cycles at pc=3008: pc, if_id_instr (35080001), if_id_valid all frozen. Resume at 300C next edge.
- BRANCH with if_id_pc4=3030, imm16=FFFC:
  - pc <= 3020 next edge.
  - if_id_valid=0, if_id_instr=0 the same edge (IF_DELAY_SLOT_EN undefined).
  - With the macro defined, valid=1 and the fetched word is retained.
- JUMP instr_index=0000C03, if_id_pc4=3010 → pc=300C. JR rs_data=0000_3013 → pc=3010.
- Redirect asserted together with stall → no change. Redirect asserted while if_id_valid=0 → sequential step only.
- Assert rst mid-run while pc=301C, asynchronously between edges:
  - pc=3000, if_id_valid=0, if_id_instr=0 immediately, without waiting for a clock.
  - Also cover pc=3FFC+4 → imem_addr wraps to 0.
